// File: rtl/instruction_decoder.sv
// Fetch-side instruction decoder for the MPU341 core: instruction register, zero flag,
// combinational datapath decode and jump-squash control towards program_sequencer.
module instruction_decoder (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sync_reset,
    input  logic [7:0] pm_data,
    input  logic       alu_zero,
    output logic [7:0] ir,
    output logic       jmp,
    output logic       jmp_nz,
    output logic [3:0] jmp_addr,
    output logic       dont_jmp,
    output logic [7:0] reg_en,
    output logic [3:0] src_sel,
    output logic       alu_en,
    output logic [2:0] alu_func,
    output logic [2:0] alu_y_sel
);

    localparam logic [7:0] NOP_OPCODE = 8'hC0;

    logic [7:0] ir_r;
    logic       zero_r;
    logic       taken_s;
    logic       jmp_s;
    logic       jmp_nz_s;
    logic [7:0] reg_en_s;
    logic [3:0] src_sel_s;
    logic       alu_en_s;
    logic [2:0] alu_func_s;
    logic [2:0] alu_y_sel_s;

    // Squash depends only on the IR and flag, so no squash state survives any reset.
    assign taken_s = jmp_s | (jmp_nz_s & ~zero_r);

    // Instruction register and zero flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_r   <= NOP_OPCODE;
            zero_r <= 1'b0;
        end else if (sync_reset) begin
            ir_r   <= NOP_OPCODE;
            zero_r <= 1'b0;
        end else begin
            ir_r <= taken_s ? NOP_OPCODE : pm_data;
            if (alu_en_s) begin
                zero_r <= alu_zero;
            end else begin
                zero_r <= zero_r;
            end
        end
    end

    // Opcode decode: move 0ddd_ssss, ALU 10ff_fyyy, NOP 110x_xxxx, jmp 1110_aaaa, jmp_nz 1111_aaaa.
    always_comb begin
        jmp_s       = 1'b0;
        jmp_nz_s    = 1'b0;
        reg_en_s    = 8'h00;
        src_sel_s   = 4'h0;
        alu_en_s    = 1'b0;
        alu_func_s  = 3'b000;
        alu_y_sel_s = 3'b000;
        case (ir_r[7:4])
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
                reg_en_s  = 8'h01 << ir_r[6:4];
                src_sel_s = ir_r[3:0];
            end
            4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
                alu_en_s    = 1'b1;
                alu_func_s  = ir_r[5:3];
                alu_y_sel_s = ir_r[2:0];
            end
            4'b1110: begin
                jmp_s = 1'b1;
            end
            4'b1111: begin
                jmp_nz_s = 1'b1;
            end
            default: begin
                jmp_s    = 1'b0;
                jmp_nz_s = 1'b0;
            end
        endcase
    end

    assign ir        = ir_r;
    assign dont_jmp  = zero_r;
    assign jmp       = jmp_s;
    assign jmp_nz    = jmp_nz_s;
    assign jmp_addr  = ir_r[3:0];
    assign reg_en    = reg_en_s;
    assign src_sel   = src_sel_s;
    assign alu_en    = alu_en_s;
    assign alu_func  = alu_func_s;
    assign alu_y_sel = alu_y_sel_s;

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed table-driven bench for instruction_decoder, plus hand-written reset sequences.
module tb_instruction_decoder;

    logic       clk;
    logic       reset_n;
    logic       sync_reset;
    logic [7:0] pm_data;
    logic       alu_zero;
    logic [7:0] ir;
    logic       jmp;
    logic       jmp_nz;
    logic [3:0] jmp_addr;
    logic       dont_jmp;
    logic [7:0] reg_en;
    logic [3:0] src_sel;
    logic       alu_en;
    logic [2:0] alu_func;
    logic [2:0] alu_y_sel;

    typedef struct packed {
        logic [7:0] ir;
        logic       jmp;
        logic       jmp_nz;
        logic [3:0] jmp_addr;
        logic       dont_jmp;
        logic [7:0] reg_en;
        logic [3:0] src_sel;
        logic       alu_en;
        logic [2:0] alu_func;
        logic [2:0] alu_y_sel;
    } outs_t;

    typedef struct {
        logic       sr;
        logic [7:0] pm;
        logic       az;
        outs_t      exp;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];
    int n_vec;
    int n_fail;

    instruction_decoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sync_reset(sync_reset),
        .pm_data   (pm_data),
        .alu_zero  (alu_zero),
        .ir        (ir),
        .jmp       (jmp),
        .jmp_nz    (jmp_nz),
        .jmp_addr  (jmp_addr),
        .dont_jmp  (dont_jmp),
        .reg_en    (reg_en),
        .src_sel   (src_sel),
        .alu_en    (alu_en),
        .alu_func  (alu_func),
        .alu_y_sel (alu_y_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t o(input logic [7:0] i, input logic j, input logic jn,
                                input logic [3:0] a, input logic dz, input logic [7:0] re,
                                input logic [3:0] ss, input logic ae, input logic [2:0] fn,
                                input logic [2:0] ys);
        outs_t r;
        r = {i, j, jn, a, dz, re, ss, ae, fn, ys};
        return r;
    endfunction

    function automatic outs_t nop_o(input logic [7:0] i, input logic dz);
        return o(i, 1'b0, 1'b0, i[3:0], dz, 8'h00, 4'h0, 1'b0, 3'd0, 3'd0);
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t act;
        act = {ir, jmp, jmp_nz, jmp_addr, dont_jmp, reg_en, src_sel, alu_en, alu_func, alu_y_sel};
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got ir=%h jmp=%b jnz=%b addr=%h dz=%b reg_en=%h src=%h alu_en=%b fn=%0d ys=%0d, expected ir=%h jmp=%b jnz=%b addr=%h dz=%b reg_en=%h src=%h alu_en=%b fn=%0d ys=%0d",
                     name, act.ir, act.jmp, act.jmp_nz, act.jmp_addr, act.dont_jmp, act.reg_en,
                     act.src_sel, act.alu_en, act.alu_func, act.alu_y_sel,
                     exp.ir, exp.jmp, exp.jmp_nz, exp.jmp_addr, exp.dont_jmp, exp.reg_en,
                     exp.src_sel, exp.alu_en, exp.alu_func, exp.alu_y_sel);
        end
    endtask

    task automatic step(input logic sr, input logic [7:0] pm, input logic az);
        @(negedge clk);
        sync_reset = sr;
        pm_data    = pm;
        alu_zero   = az;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;

        // Row inputs are applied for one cycle; expectation is the state after that edge.
        vecs[0]  = '{1'b0, 8'hE7, 1'b0, o(8'hE7, 1'b1, 1'b0, 4'h7, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 3'd0)};
        vecs[1]  = '{1'b0, 8'h13, 1'b0, nop_o(8'hC0, 1'b0)};
        vecs[2]  = '{1'b0, 8'h31, 1'b0, o(8'h31, 1'b0, 1'b0, 4'h1, 1'b0, 8'h08, 4'h1, 1'b0, 3'd0, 3'd0)};
        vecs[3]  = '{1'b0, 8'h8A, 1'b0, o(8'h8A, 1'b0, 1'b0, 4'hA, 1'b0, 8'h00, 4'h0, 1'b1, 3'd1, 3'd2)};
        vecs[4]  = '{1'b0, 8'hF3, 1'b1, o(8'hF3, 1'b0, 1'b1, 4'h3, 1'b1, 8'h00, 4'h0, 1'b0, 3'd0, 3'd0)};
        vecs[5]  = '{1'b0, 8'h25, 1'b0, o(8'h25, 1'b0, 1'b0, 4'h5, 1'b1, 8'h04, 4'h5, 1'b0, 3'd0, 3'd0)};
        vecs[6]  = '{1'b0, 8'h8A, 1'b0, o(8'h8A, 1'b0, 1'b0, 4'hA, 1'b1, 8'h00, 4'h0, 1'b1, 3'd1, 3'd2)};
        vecs[7]  = '{1'b0, 8'hF3, 1'b0, o(8'hF3, 1'b0, 1'b1, 4'h3, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 3'd0)};
        vecs[8]  = '{1'b0, 8'h25, 1'b0, nop_o(8'hC0, 1'b0)};
        vecs[9]  = '{1'b0, 8'h8A, 1'b0, o(8'h8A, 1'b0, 1'b0, 4'hA, 1'b0, 8'h00, 4'h0, 1'b1, 3'd1, 3'd2)};
        vecs[10] = '{1'b0, 8'h10, 1'b1, o(8'h10, 1'b0, 1'b0, 4'h0, 1'b1, 8'h02, 4'h0, 1'b0, 3'd0, 3'd0)};
        vecs[11] = '{1'b0, 8'h10, 1'b0, o(8'h10, 1'b0, 1'b0, 4'h0, 1'b1, 8'h02, 4'h0, 1'b0, 3'd0, 3'd0)};
        vecs[12] = '{1'b0, 8'h10, 1'b1, o(8'h10, 1'b0, 1'b0, 4'h0, 1'b1, 8'h02, 4'h0, 1'b0, 3'd0, 3'd0)};
        vecs[13] = '{1'b0, 8'h10, 1'b0, o(8'h10, 1'b0, 1'b0, 4'h0, 1'b1, 8'h02, 4'h0, 1'b0, 3'd0, 3'd0)};
        vecs[14] = '{1'b0, 8'hE7, 1'b0, o(8'hE7, 1'b1, 1'b0, 4'h7, 1'b1, 8'h00, 4'h0, 1'b0, 3'd0, 3'd0)};
        vecs[15] = '{1'b0, 8'hE2, 1'b0, nop_o(8'hC0, 1'b1)};
        vecs[16] = '{1'b0, 8'hE2, 1'b0, o(8'hE2, 1'b1, 1'b0, 4'h2, 1'b1, 8'h00, 4'h0, 1'b0, 3'd0, 3'd0)};
        vecs[17] = '{1'b0, 8'hE5, 1'b0, nop_o(8'hC0, 1'b1)};
        vecs[18] = '{1'b0, 8'hE7, 1'b0, o(8'hE7, 1'b1, 1'b0, 4'h7, 1'b1, 8'h00, 4'h0, 1'b0, 3'd0, 3'd0)};
        vecs[19] = '{1'b1, 8'h31, 1'b0, nop_o(8'hC0, 1'b0)};
        vecs[20] = '{1'b0, 8'h31, 1'b0, o(8'h31, 1'b0, 1'b0, 4'h1, 1'b0, 8'h08, 4'h1, 1'b0, 3'd0, 3'd0)};
        vecs[21] = '{1'b0, 8'h9F, 1'b0, o(8'h9F, 1'b0, 1'b0, 4'hF, 1'b0, 8'h00, 4'h0, 1'b1, 3'd3, 3'd7)};
        vecs[22] = '{1'b1, 8'hC5, 1'b1, nop_o(8'hC0, 1'b0)};
        vecs[23] = '{1'b0, 8'hC5, 1'b0, nop_o(8'hC5, 1'b0)};
        vecs[24] = '{1'b0, 8'h7F, 1'b0, o(8'h7F, 1'b0, 1'b0, 4'hF, 1'b0, 8'h80, 4'hF, 1'b0, 3'd0, 3'd0)};
        vecs[25] = '{1'b0, 8'hF9, 1'b0, o(8'hF9, 1'b0, 1'b1, 4'h9, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 3'd0)};
        vecs[26] = '{1'b0, 8'hE7, 1'b0, nop_o(8'hC0, 1'b0)};

        reset_n    = 1'b0;
        sync_reset = 1'b0;
        pm_data    = 8'h25;
        alu_zero   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", nop_o(8'hC0, 1'b0));

        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", o(8'h25, 1'b0, 1'b0, 4'h5, 1'b0, 8'h04, 4'h5, 1'b0, 3'd0, 3'd0));

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].sr, vecs[i].pm, vecs[i].az);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Async reset pulse between edges with a jump in the IR and the flag set.
        step(1'b0, 8'h8A, 1'b0);
        step(1'b0, 8'hE7, 1'b1);
        check("pre_async", o(8'hE7, 1'b1, 1'b0, 4'h7, 1'b1, 8'h00, 4'h0, 1'b0, 3'd0, 3'd0));
        #1;
        reset_n = 1'b0;
        #1;
        check("async_immediate", nop_o(8'hC0, 1'b0));
        reset_n = 1'b1;
        step(1'b0, 8'h25, 1'b0);
        check("after_async", o(8'h25, 1'b0, 1'b0, 4'h5, 1'b0, 8'h04, 4'h5, 1'b0, 3'd0, 3'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_decoder.md
# instruction_decoder

Fetch-side partner of `program_sequencer` in the MPU341 core. It registers the instruction returned from program memory at `pm_addr` into the instruction register (IR), decodes the IR into datapath enables, and drives the sequencer's `jmp`, `jmp_nz`, `jmp_addr` and `dont_jmp` inputs. It holds the zero flag and squashes the single sequentially fetched instruction that follows a taken jump. It sits between program memory, `program_sequencer` and the register/ALU datapath.

## Interface
- `NOP_OPCODE`, 8'hC0: value loaded into the IR on reset, on `sync_reset` and on squash.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sync_reset`  in  1  synchronous reset, the same net as the sequencer's `sync_reset`.
- `pm_data`  in  8  instruction at the current `pm_addr`; combinational ROM output.
- `alu_zero`  in  1  ALU zero result for the instruction currently held in the IR.
- `ir`  out  8  instruction register, for debug.
- `jmp`  out  1  unconditional jump decode.
- `jmp_nz`  out  1  jump-if-not-zero decode.
- `jmp_addr`  out  4  jump target, `ir[3:0]`.
- `dont_jmp`  out  1  registered zero flag; the sequencer suppresses `jmp_nz` while it is high.
- `reg_en`  out  8  one-hot register load enable.
- `src_sel`  out  4  move source select.
- `alu_en`  out  1  ALU operation valid.
- `alu_func`  out  3  ALU function code.
- `alu_y_sel`  out  3  ALU Y operand register select.

## Operation
- **IR update, every edge, in priority order:**
  1. `sync_reset`=1: IR <= `NOP_OPCODE`.
  2. `taken`=1: IR <= `NOP_OPCODE` (squash).
  3. Otherwise: IR <= `pm_data`.
- **Taken condition:** `taken` = `jmp` | (`jmp_nz` & ~`dont_jmp`). It is internal and combinational from the IR and the zero flag.
- **Decode is purely combinational from the IR.** All outputs are 0 unless the opcode listed asserts them.
- **`0ddd_ssss` (move):**
  - `reg_en` = 1 << `ddd`.
  - `src_sel` = `ssss`.
- **`10ff_fyyy` (ALU):**
  - `alu_en`=1.
  - `alu_func`=`fff`.
  - `alu_y_sel`=`yyy`.
- **`110x_xxxx`:** NOP.
- **`1110_aaaa`:**
  - `jmp`=1.
  - `jmp_addr`=`aaaa`.
- **`1111_aaaa`:**
  - `jmp_nz`=1.
  - `jmp_addr`=`aaaa`.
- **`jmp_addr` for every other opcode:** still equals `ir[3:0]`. The sequencer qualifies it with `jmp` and `jmp_nz`.
- **Zero flag (`dont_jmp`):**
  - `sync_reset`=1: cleared to 0. This takes priority.
  - Else `alu_en`=1: loads `alu_zero`.
  - Otherwise it holds.
  - Move, jump and NOP instructions never modify it.
- **Squashed instruction:** it is a NOP in every respect. It produces no enables and no flag update.

## Timing
- **Async reset:** `reset_n` low forces IR=8'hC0 and `dont_jmp`=0 immediately. The decode outputs follow to all zeros: `jmp_addr`=0, `reg_en`=0, `alu_en`=0, `jmp`=0, `jmp_nz`=0.
- **Reset release:** the first edge after release loads `pm_data`.
- **Fetch latency:** the instruction at `pm_addr` in cycle t appears in the IR, with its decode, in cycle t+1.
- **Jump timing:**
  - The jump is in the IR in cycle t, and `jmp` is seen by the sequencer in the same cycle t.
  - The sequential instruction fetched during t is replaced by NOP in cycle t+1.
  - The target instruction is in the IR in cycle t+2.
  - A taken jump costs exactly one bubble.
- **Not-taken `jmp_nz`:** no bubble; the next sequential instruction executes in t+1.
- **ALU followed by `jmp_nz`:** an ALU op in cycle t updates the flag at the end of t. A `jmp_nz` in t+1 sees the new flag. There are no hazard cycles.
- **Jump to itself:** IR alternates jump, NOP, jump, and so on. This is legal.
- **Two consecutive jumps:** the second one is squashed and never executes.
- **`sync_reset` together with a taken jump:** `sync_reset` wins. IR=NOP and the flag is cleared.
- **`reset_n` asserted mid-jump:** no squash state survives, because the squash is derived only from the IR and the flag.
- **ALU op in the IR with `sync_reset`=1:** the flag clears and is not loaded.

## Test plan
1. **Reset:** hold `reset_n`=0 with `pm_data`=8'h25. Expect `ir`=8'hC0 and all outputs 0. Release; after 1 edge expect `ir`=8'h25, `reg_en`=8'h04, `src_sel`=4'h5.
2. **Unconditional jump:** drive `pm_data`=8'hE7, 8'h13, 8'h31 on successive cycles. Expect:
   - `jmp`=1 and `jmp_addr`=7 in cycle 1.
   - `ir`=8'hC0 and `reg_en`=0 in cycle 2.
   - `ir`=8'h31 in cycle 3.
3. **`jmp_nz` not taken:** drive 8'h8A with `alu_zero`=1, then 8'hF3, then 8'h25. Expect:
   - `alu_en`=1, `alu_func`=1, `alu_y_sel`=2.
   - Next cycle `dont_jmp`=1 and `jmp_nz`=1.
   - Following cycle `ir`=8'h25, not squashed.
4. **`jmp_nz` taken:** same sequence with `alu_zero`=0. Expect `dont_jmp`=0, `jmp_nz`=1, then `ir`=8'hC0.
5. **Flag isolation:** ALU with `alu_zero`=1, then move 8'h10 while `alu_zero` toggles. Expect `dont_jmp` stays 1.
6. **Resets:**
   - Assert `sync_reset` while the IR holds 8'hE7. Expect next `ir`=8'hC0 and `dont_jmp`=0.
   - Pulse `reset_n` low between edges. Expect immediate `ir`=8'hC0.
